// File: rtl/sdram_burst_arbiter.sv
// sdram_burst_arbiter
//   Schedules all SDRAM traffic for the camera-to-VGA frame buffer: one burst
//   command at a time (write, read or refresh) chosen from the camera write
//   FIFO level, the VGA read FIFO level and a refresh timer. Generates linear
//   frame offsets for writer and reader with per-frame restart.
//
//   Build option: define SDRAM_PINGPONG_EN for double buffering (the writer
//   toggles banks on each restart and the reader takes the opposite bank).
//   Without it both banks are 0 and a single buffer is shared.
//
// Ports
//   clk, rst           : SDRAM clock, asynchronous active-high reset
//   init_done          : SDRAM power-up init complete (level)
//   wr_usedw, rd_usedw : write-FIFO words available / read-FIFO words held
//   wr_frame_start     : camera vsync pulse (clk domain)
//   rd_frame_start     : VGA vsync pulse (clk domain)
//   cmd_req/type/addr/len, cmd_ack, cmd_done : command handshake
//                        (type 00 write, 01 read, 10 refresh; addr MSB = bank)
//   ref_overrun        : sticky, a refresh interval was missed
module sdram_burst_arbiter #(
  parameter int BURST_LEN   = 256,
  parameter int FRAME_WORDS = 786432,
  parameter int ADDR_W      = 22,
  parameter int CNT_W       = 10,
  parameter int RD_LOW      = 128,
  parameter int REF_PERIOD  = 780
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              init_done,
  input  logic [CNT_W-1:0]  wr_usedw,
  input  logic [CNT_W-1:0]  rd_usedw,
  input  logic              wr_frame_start,
  input  logic              rd_frame_start,
  output logic              cmd_req,
  output logic [1:0]        cmd_type,
  output logic [ADDR_W:0]   cmd_addr,
  output logic [CNT_W-1:0]  cmd_len,
  input  logic              cmd_ack,
  input  logic              cmd_done,
  output logic              ref_overrun
);

  typedef enum logic [1:0] {S_WAIT_INIT, S_ARB, S_REQ, S_BUSY} state_t;
  typedef enum logic [1:0] {CMD_WR = 2'b00, CMD_RD = 2'b01, CMD_REF = 2'b10} cmd_t;

  localparam int               REF_W      = (REF_PERIOD > 1) ? $clog2(REF_PERIOD) : 1;
  localparam logic [ADDR_W:0]   FRAME_END  = (ADDR_W+1)'(FRAME_WORDS);
  localparam logic [ADDR_W:0]   BURST_STEP = (ADDR_W+1)'(BURST_LEN);
  localparam logic [CNT_W-1:0]  LEN_DATA   = CNT_W'(BURST_LEN);
  localparam logic [CNT_W-1:0]  RD_LOW_L   = CNT_W'(RD_LOW);
  localparam logic [CNT_W-1:0]  RD_ROOM    = CNT_W'((2**CNT_W) - 1 - BURST_LEN);
  localparam logic [REF_W-1:0]  REF_LAST   = REF_W'(REF_PERIOD - 1);

  state_t             state_q, state_d;
  cmd_t               cmd_type_q, cmd_type_d;
  logic               cmd_req_q, cmd_req_d;
  logic [ADDR_W:0]    cmd_addr_q, cmd_addr_d;
  logic [CNT_W-1:0]   cmd_len_q, cmd_len_d;
  logic [REF_W-1:0]   ref_cnt_q, ref_cnt_d;
  logic               ref_pending_q, ref_pending_d;
  logic               ref_overrun_q, ref_overrun_d;
  logic               rr_last_q, rr_last_d;          // 1 = last data grant was a read
  logic [ADDR_W-1:0]  wr_off_q, wr_off_d, rd_off_q, rd_off_d;
  logic               wr_restart_pending_q, wr_restart_pending_d;
  logic               rd_restart_pending_q, rd_restart_pending_d;

  logic               cmd_active, done_evt, ref_acked, ref_wrap;
  logic               wr_active, rd_active, wr_done, rd_done;
  logic               wr_restart, rd_restart, wr_apply, rd_apply;
  logic [ADDR_W:0]    wr_sum, rd_sum;
  logic [ADDR_W-1:0]  wr_off_eff, rd_off_eff;
  logic               wr_bank, rd_bank;
  logic               rd_urgent, wr_ready, rd_ready;

  assign cmd_active = (state_q == S_REQ) || (state_q == S_BUSY);
  // A done coinciding with the ack completes the command directly from REQ.
  assign done_evt   = cmd_done && ((state_q == S_BUSY) || ((state_q == S_REQ) && cmd_ack));
  assign ref_acked  = (state_q == S_REQ) && cmd_ack && (cmd_type_q == CMD_REF);
  assign wr_active  = cmd_active && (cmd_type_q == CMD_WR);
  assign rd_active  = cmd_active && (cmd_type_q == CMD_RD);
  assign wr_done    = done_evt && (cmd_type_q == CMD_WR);
  assign rd_done    = done_evt && (cmd_type_q == CMD_RD);

  assign rd_urgent  = rd_usedw < RD_LOW_L;
  assign wr_ready   = wr_usedw >= LEN_DATA;
  assign rd_ready   = rd_usedw <= RD_ROOM;

  // Refresh timer, pending request and sticky overrun.
  always_comb begin
    ref_cnt_d     = ref_cnt_q;
    ref_pending_d = ref_pending_q;
    ref_overrun_d = ref_overrun_q;
    ref_wrap      = 1'b0;
    if (state_q == S_WAIT_INIT) begin
      ref_cnt_d = '0;
    end else if (ref_cnt_q == REF_LAST) begin
      ref_cnt_d = '0;
      ref_wrap  = 1'b1;
    end else begin
      ref_cnt_d = ref_cnt_q + 1'b1;
    end
    if (ref_acked) ref_pending_d = 1'b0;
    if (ref_wrap) begin
      ref_pending_d = 1'b1;
      if (ref_pending_q && !ref_acked) ref_overrun_d = 1'b1;
    end
  end

  // Frame offsets. A restart applies once no command of that side is in
  // flight, or on that command's done in place of the normal advance.
  always_comb begin
    wr_restart           = wr_restart_pending_q | wr_frame_start;
    rd_restart           = rd_restart_pending_q | rd_frame_start;
    wr_apply             = wr_restart && (!wr_active || wr_done);
    rd_apply             = rd_restart && (!rd_active || rd_done);
    wr_sum               = {1'b0, wr_off_q} + BURST_STEP;
    rd_sum               = {1'b0, rd_off_q} + BURST_STEP;
    wr_restart_pending_d = wr_restart && !wr_apply;
    rd_restart_pending_d = rd_restart && !rd_apply;
    wr_off_d             = wr_off_q;
    rd_off_d             = rd_off_q;
    if (wr_apply)     wr_off_d = '0;
    else if (wr_done) wr_off_d = (wr_sum == FRAME_END) ? '0 : wr_sum[ADDR_W-1:0];
    if (rd_apply)     rd_off_d = '0;
    else if (rd_done) rd_off_d = (rd_sum == FRAME_END) ? '0 : rd_sum[ADDR_W-1:0];
    // Offset a grant in this cycle should use (restart already folded in).
    wr_off_eff           = wr_apply ? '0 : wr_off_q;
    rd_off_eff           = rd_apply ? '0 : rd_off_q;
  end

`ifdef SDRAM_PINGPONG_EN
  logic wr_bank_q, wr_bank_d, rd_bank_q, rd_bank_d;

  always_comb begin
    wr_bank_d = wr_apply ? ~wr_bank_q : wr_bank_q;
    // Reader takes the bank opposite the writer's post-restart bank.
    rd_bank_d = rd_apply ? ~wr_bank_d : rd_bank_q;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_bank_q <= 1'b0;
      rd_bank_q <= 1'b0;
    end else begin
      wr_bank_q <= wr_bank_d;
      rd_bank_q <= rd_bank_d;
    end
  end

  assign wr_bank = wr_bank_d;
  assign rd_bank = rd_bank_d;
`else
  assign wr_bank = 1'b0;
  assign rd_bank = 1'b0;
`endif

  // Command FSM: arbitration in ARB, handshake in REQ, completion in BUSY.
  always_comb begin
    state_d    = state_q;
    cmd_type_d = cmd_type_q;
    cmd_addr_d = cmd_addr_q;
    cmd_len_d  = cmd_len_q;
    rr_last_d  = rr_last_q;
    unique case (state_q)
      S_WAIT_INIT: if (init_done) state_d = S_ARB;
      S_ARB: begin
        if (!init_done) begin
          state_d = S_WAIT_INIT;
        end else if (ref_pending_q) begin
          state_d    = S_REQ;
          cmd_type_d = CMD_REF;
          cmd_addr_d = '0;
          cmd_len_d  = CNT_W'(1);
        end else if (rd_urgent || (rd_ready && (!wr_ready || !rr_last_q))) begin
          state_d    = S_REQ;
          cmd_type_d = CMD_RD;
          cmd_addr_d = {rd_bank, rd_off_eff};
          cmd_len_d  = LEN_DATA;
          rr_last_d  = 1'b1;
        end else if (wr_ready) begin
          state_d    = S_REQ;
          cmd_type_d = CMD_WR;
          cmd_addr_d = {wr_bank, wr_off_eff};
          cmd_len_d  = LEN_DATA;
          rr_last_d  = 1'b0;
        end
      end
      S_REQ: begin
        if (cmd_ack) begin
          if (cmd_done) state_d = init_done ? S_ARB : S_WAIT_INIT;
          else          state_d = S_BUSY;
        end
      end
      S_BUSY: if (cmd_done) state_d = init_done ? S_ARB : S_WAIT_INIT;
      default: state_d = S_WAIT_INIT;
    endcase
    cmd_req_d = (state_d == S_REQ);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q              <= S_WAIT_INIT;
      cmd_req_q            <= 1'b0;
      cmd_type_q           <= CMD_WR;
      cmd_addr_q           <= '0;
      cmd_len_q            <= '0;
      ref_cnt_q            <= '0;
      ref_pending_q        <= 1'b0;
      ref_overrun_q        <= 1'b0;
      rr_last_q            <= 1'b1;
      wr_off_q             <= '0;
      rd_off_q             <= '0;
      wr_restart_pending_q <= 1'b0;
      rd_restart_pending_q <= 1'b0;
    end else begin
      state_q              <= state_d;
      cmd_req_q            <= cmd_req_d;
      cmd_type_q           <= cmd_type_d;
      cmd_addr_q           <= cmd_addr_d;
      cmd_len_q            <= cmd_len_d;
      ref_cnt_q            <= ref_cnt_d;
      ref_pending_q        <= ref_pending_d;
      ref_overrun_q        <= ref_overrun_d;
      rr_last_q            <= rr_last_d;
      wr_off_q             <= wr_off_d;
      rd_off_q             <= rd_off_d;
      wr_restart_pending_q <= wr_restart_pending_d;
      rd_restart_pending_q <= rd_restart_pending_d;
    end
  end

  assign cmd_req     = cmd_req_q;
  assign cmd_type    = cmd_type_q;
  assign cmd_addr    = cmd_addr_q;
  assign cmd_len     = cmd_len_q;
  assign ref_overrun = ref_overrun_q;

endmodule

// File: doc/sdram_burst_arbiter.md
Name: sdram_burst_arbiter

Overview:
- Schedules all SDRAM traffic for the camera-to-VGA frame buffer.
- Watches the camera write-FIFO fill level, the VGA read-FIFO fill level and a refresh timer, then issues one burst command at a time to the SDRAM command engine.
- Generates linear frame addresses for the writer and reader, with per-frame restart.
- Sits between the FIFOs / sync sources and the SDRAM command/phy layer, in the 100 MHz SDRAM clock domain.

Parameters:
- BURST_LEN, 256: words per read/write burst; power of two.
- FRAME_WORDS, 786432: words per frame (1024x768 RGB565); a multiple of BURST_LEN.
- ADDR_W, 22: frame offset address width.
- CNT_W, 10: FIFO used-word count width.
- RD_LOW, 128: read-FIFO level below which a read is urgent.
- REF_PERIOD, 780: clocks between refresh requests (7.8 us at 100 MHz).

Ports:
- clk, in, 1: SDRAM controller clock.
- rst, in, 1: asynchronous active-high reset.
- init_done, in, 1: SDRAM power-up init complete; level.
- wr_usedw, in, CNT_W: camera write-FIFO words available.
- rd_usedw, in, CNT_W: VGA read-FIFO words held.
- wr_frame_start, in, 1: one-cycle pulse at camera vsync, already synchronised to clk.
- rd_frame_start, in, 1: one-cycle pulse at VGA vsync, already synchronised to clk.
- cmd_req, out, 1: command request.
- cmd_type, out, 2: 00 write, 01 read, 10 refresh.
- cmd_addr, out, ADDR_W+1: MSB is the buffer bank, low bits are the word offset.
- cmd_len, out, CNT_W: burst length.
- cmd_ack, in, 1: command accepted.
- cmd_done, in, 1: command complete; one-cycle pulse.
- ref_overrun, out, 1: sticky flag, a refresh interval was missed.

Behaviour:
- Reset values: cmd_req=0, cmd_type=00, cmd_addr=0, cmd_len=0, ref_overrun=0, both address counters=0, refresh counter=0, ref_pending=0, rr_last=read.
- Clock and reset: one clock; reset is asynchronous and active-high. Reset asserted mid-burst returns to WAIT_INIT immediately and drops cmd_req.
- State machine WAIT_INIT -> ARB -> REQ -> BUSY -> ARB:
  - WAIT_INIT: stay while init_done=0. The refresh counter is held at 0.
  - ARB: pick one requester in a single cycle, then go to REQ the next cycle. If nothing qualifies, stay in ARB.
  - REQ: cmd_req=1 with cmd_type/addr/len held stable until the cycle cmd_ack=1. After that edge cmd_req=0; go to BUSY.
  - BUSY: wait for cmd_done, then go to ARB. A cmd_done in the same cycle as cmd_ack is honoured (REQ goes straight to ARB).
  - If init_done falls, finish the current command, then return to WAIT_INIT.
- Arbitration priority, evaluated in ARB:
  1. ref_pending.
  2. Urgent read: rd_usedw < RD_LOW.
  3. Write ready (wr_usedw >= BURST_LEN) and read ready (rd_usedw <= 2^CNT_W-1-BURST_LEN) both set: round-robin against rr_last.
  4. Whichever single one of write/read is ready.
- Refresh:
  - Counter runs 0..REF_PERIOD-1 once init_done=1.
  - At wrap, ref_pending is set.
  - ref_pending clears on cmd_ack of a refresh command.
  - If the counter wraps while ref_pending=1, ref_overrun is set; it clears only on rst.
  - Refresh commands use cmd_len=1 and cmd_addr=0.
- Address generation:
  - The write offset advances by BURST_LEN on cmd_done of a write.
  - Wrap: when the new offset would equal FRAME_WORDS, it becomes 0.
  - The read offset behaves identically.
  - wr_frame_start sets wr_restart_pending. The write offset zeroes when no write is in REQ/BUSY: immediately if idle, otherwise on that write's cmd_done instead of advancing. The pending flag then clears.
  - rd_frame_start behaves the same for the read side.
  - A frame_start arriving in the same cycle as the completing cmd_done takes precedence: offset becomes 0.
- Data commands: cmd_len=BURST_LEN. Without the optional feature, cmd_addr MSB=0.

Optional Feature:
- Macro: SDRAM_PINGPONG_EN.
- When defined:
  - wr_bank toggles on each applied write restart.
  - rd_bank loads ~wr_bank on each applied read restart, so the display never reads the frame being written.
  - The cmd_addr MSB is the respective bank; both banks reset to 0.
- When undefined: both banks are constant 0, and a single buffer is shared by writer and reader.

Test Plan:
- Init gating: rst pulse; init_done=0 for 50 cycles with wr_usedw=300 -> no cmd_req. Raise init_done -> write request with cmd_addr=0, cmd_len=256 within 2 cycles.
- Refresh priority and overrun: REF_PERIOD=20; hold rd_usedw=0 and wr_usedw=300, ack every command instantly, keep each BUSY 5 cycles -> a refresh issues within one command slot after each wrap. Withhold cmd_ack for 45 cycles -> ref_overrun=1 and stays 1.
- Round-robin: rd_usedw=400, wr_usedw=300 constant -> commands alternate write, read, write, read. Set rd_usedw=100 -> read wins every slot.
- Address wrap: FRAME_WORDS=1024 -> write addresses 0, 256, 512, 768, 0.
- Restart mid-burst: wr_frame_start pulsed while a write at offset 512 is BUSY -> the next write addresses 0, not 768. Repeat with the pulse coinciding with cmd_done -> next write address is 0.
- SDRAM_PINGPONG_EN: two wr_frame_starts then one rd_frame_start -> writes at MSB 0, reads at MSB 1. Without the macro, every MSB stays 0.
